// File: rtl/control_unit.sv
// Hardwired multi-cycle Mini SRC control unit: three fetch steps, then up to five
// execute steps decoded from the opcode in IR[31:27] and the branch condition flip-flop.
module control_unit #(
    parameter int             OPW    = 5,
    parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
    input  logic           Clock,
    input  logic           Clear,
    input  logic [31:0]    IR,
    input  logic           CON_FF,
    output logic           Run,
    output logic [OPW-1:0] alu_op,
    output logic           PCout, MDRout, ZHighout, ZLowout, HIout,
    output logic           LOout, InPortout, Cout, BAout, R_out,
    output logic           PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read,
    output logic           IR_enable, Y_enable, ZLowIn, ZHighIn,
    output logic           HI_enable, LO_enable, R_in, CON_enable, OutPort_enable, RAM_write,
    output logic           Gra, Grb, Grc
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } step_e;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHL  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01001, OP_ROL  = 5'b01010, OP_ADDI = 5'b01011;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_IN   = 5'b10101;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10110, OP_MFHI = 5'b10111, OP_MFLO = 5'b11000;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    step_e          step_q, step_d;
    step_e          last_s;
    logic [OPW-1:0] op_s;
    logic           ir_unused_s;

    assign op_s        = IR[31:32-OPW];
    assign ir_unused_s = ^IR[31-OPW:0];

    // Final execute step of each instruction class; the step after it is the next fetch.
    always_comb begin
        last_s = S_T3;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_s = S_T5;
            OP_MUL, OP_DIV, OP_BR:            last_s = S_T6;
            OP_NEG, OP_NOT:                   last_s = S_T4;
            OP_LD, OP_ST:                     last_s = S_T7;
            default:                          last_s = S_T3;
        endcase
    end

    // Step sequencing: fetch T0-T2, execute up to last_s, halt parks until Clear.
    always_comb begin
        step_d = step_q;
        case (step_q)
            S_RST:   step_d = S_T0;
            S_T0:    step_d = S_T1;
            S_T1:    step_d = S_T2;
            S_T2:    step_d = S_T3;
            S_T3:    step_d = (op_s == OP_HALT) ? S_HALT : ((last_s == S_T3) ? S_T0 : S_T4);
            S_T4:    step_d = (last_s == S_T4) ? S_T0 : S_T5;
            S_T5:    step_d = (last_s == S_T5) ? S_T0 : S_T6;
            S_T6:    step_d = (last_s == S_T6) ? S_T0 : S_T7;
            S_T7:    step_d = S_T0;
            S_HALT:  step_d = S_HALT;
            default: step_d = S_RST;
        endcase
    end

    // Step register; Clear wins over every step including HALT.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            step_q <= S_RST;
        end else begin
            step_q <= step_d;
        end
    end

    // Strobe decode of (step, opcode, CON_FF); IR is already the new instruction from T3 on.
    always_comb begin
        Run = (step_q != S_HALT);
        alu_op = '0;
        {PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, R_out} = 10'd0;
        {PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable, ZLowIn, ZHighIn} = 9'd0;
        {HI_enable, LO_enable, R_in, CON_enable, OutPort_enable, RAM_write} = 6'd0;
        {Gra, Grb, Grc} = 3'd0;
        case (step_q)
            S_T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
            S_T1: begin ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1; MDR_enable = 1'b1; end
            S_T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
            S_T3: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    OP_MUL, OP_DIV:   begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    OP_NEG, OP_NOT:   begin Grb = 1'b1; R_out = 1'b1; alu_op = op_s; ZLowIn = 1'b1; end
                    OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
                    OP_BR:   begin Gra = 1'b1; R_out = 1'b1; CON_enable = 1'b1; end
                    OP_JR:   begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                    OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                        begin Grc = 1'b1; R_out = 1'b1; alu_op = op_s; ZLowIn = 1'b1; end
                    OP_ADDI, OP_ANDI, OP_ORI: begin Cout = 1'b1; alu_op = op_s; ZLowIn = 1'b1; end
                    OP_MUL, OP_DIV:
                        begin Grb = 1'b1; R_out = 1'b1; alu_op = op_s; ZLowIn = 1'b1; ZHighIn = 1'b1; end
                    OP_NEG, OP_NOT:   begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; alu_op = ADD_OP; ZLowIn = 1'b1; end
                    OP_BR:   begin PCout = 1'b1; Y_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    OP_MUL, OP_DIV: begin ZLowout = 1'b1; LO_enable = 1'b1; end
                    OP_LD, OP_ST:   begin ZLowout = 1'b1; MAR_enable = 1'b1; end
                    OP_BR:          begin Cout = 1'b1; alu_op = ADD_OP; ZLowIn = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_s)
                    OP_MUL, OP_DIV: begin ZHighout = 1'b1; HI_enable = 1'b1; end
                    OP_LD:          begin MDR_read = 1'b1; MDR_enable = 1'b1; end
                    OP_ST:          begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
                    OP_BR: begin
                        if (CON_FF) begin
                            ZLowout = 1'b1; PC_enable = 1'b1;
                        end else begin
                            ZLowout = 1'b0; PC_enable = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_s)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    OP_ST:   RAM_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction reference model pushes the
// expected output vector of every cycle; a negedge monitor pops and compares.
module tb_control_unit;
    typedef logic [33:0] vec_t;

    localparam vec_t PCO  = 34'd1 << 0,  MDRO = 34'd1 << 1,  ZHO  = 34'd1 << 2,  ZLO  = 34'd1 << 3;
    localparam vec_t HIO  = 34'd1 << 4,  LOO  = 34'd1 << 5,  INO  = 34'd1 << 6,  COUT = 34'd1 << 7;
    localparam vec_t BAO  = 34'd1 << 8,  ROUT = 34'd1 << 9,  GRC  = 34'd1 << 10, GRB  = 34'd1 << 11;
    localparam vec_t GRA  = 34'd1 << 12, PCE  = 34'd1 << 13, INC  = 34'd1 << 14, MARE = 34'd1 << 15;
    localparam vec_t MDRE = 34'd1 << 16, MDRR = 34'd1 << 17, IRE  = 34'd1 << 18, YE   = 34'd1 << 19;
    localparam vec_t ZLI  = 34'd1 << 20, ZHI  = 34'd1 << 21, HIE  = 34'd1 << 22, LOE  = 34'd1 << 23;
    localparam vec_t RIN  = 34'd1 << 24, CONE = 34'd1 << 25, OPE  = 34'd1 << 26, RAMW = 34'd1 << 27;
    localparam vec_t RUN  = 34'd1 << 33;

    logic        clk, Clear, CON_FF;
    logic [31:0] IR;
    logic        Run;
    logic [4:0]  alu_op;
    logic PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, R_out;
    logic PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable, ZLowIn, ZHighIn;
    logic HI_enable, LO_enable, R_in, CON_enable, OutPort_enable, RAM_write, Gra, Grb, Grc;
    vec_t act;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    control_unit dut (
        .Clock(clk), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Run(Run), .alu_op(alu_op),
        .PCout(PCout), .MDRout(MDRout), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIout(HIout),
        .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .R_out(R_out),
        .PC_enable(PC_enable), .IncPC(IncPC), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
        .MDR_read(MDR_read), .IR_enable(IR_enable), .Y_enable(Y_enable), .ZLowIn(ZLowIn),
        .ZHighIn(ZHighIn), .HI_enable(HI_enable), .LO_enable(LO_enable), .R_in(R_in),
        .CON_enable(CON_enable), .OutPort_enable(OutPort_enable), .RAM_write(RAM_write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc)
    );

    assign act = {Run, alu_op, RAM_write, OutPort_enable, CON_enable, R_in, LO_enable, HI_enable,
                  ZHighIn, ZLowIn, Y_enable, IR_enable, MDR_read, MDR_enable, MAR_enable, IncPC,
                  PC_enable, Gra, Grb, Grc, R_out, BAout, Cout, InPortout, LOout, HIout, ZLowout,
                  ZHighout, MDRout, PCout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t alu(input logic [4:0] op);
        return {1'b0, op, 28'd0};
    endfunction

    // Reference model: the cycle-by-cycle micro-steps of one instruction from its first fetch step.
    task automatic model_instr(input logic [31:0] ir, input logic con, input int limit, output int n);
        vec_t       ex[$];
        logic [4:0] op;
        op = ir[31:27];
        ex.push_back(PCO | MARE | INC | ZLI);
        ex.push_back(ZLO | PCE | MDRR | MDRE);
        ex.push_back(MDRO | IRE);
        if (op >= 5'd3 && op <= 5'd10) begin
            ex.push_back(GRB | ROUT | YE);
            ex.push_back(GRC | ROUT | alu(op) | ZLI);
            ex.push_back(ZLO | GRA | RIN);
        end else if (op >= 5'd11 && op <= 5'd13) begin
            ex.push_back(GRB | ROUT | YE);
            ex.push_back(COUT | alu(op) | ZLI);
            ex.push_back(ZLO | GRA | RIN);
        end else if (op == 5'd14 || op == 5'd15) begin
            ex.push_back(GRA | ROUT | YE);
            ex.push_back(GRB | ROUT | alu(op) | ZLI | ZHI);
            ex.push_back(ZLO | LOE);
            ex.push_back(ZHO | HIE);
        end else if (op == 5'd16 || op == 5'd17) begin
            ex.push_back(GRB | ROUT | alu(op) | ZLI);
            ex.push_back(ZLO | GRA | RIN);
        end else if (op <= 5'd2) begin
            ex.push_back(GRB | BAO | YE);
            ex.push_back(COUT | alu(5'd3) | ZLI);
            if (op == 5'd1) begin
                ex.push_back(ZLO | GRA | RIN);
            end else begin
                ex.push_back(ZLO | MARE);
                ex.push_back((op == 5'd0) ? (MDRR | MDRE) : (GRA | ROUT | MDRE));
                ex.push_back((op == 5'd0) ? (MDRO | GRA | RIN) : RAMW);
            end
        end else if (op == 5'd18) begin
            ex.push_back(GRA | ROUT | CONE);
            ex.push_back(PCO | YE);
            ex.push_back(COUT | alu(5'd3) | ZLI);
            ex.push_back(con ? (ZLO | PCE) : 34'd0);
        end else if (op == 5'd19) ex.push_back(GRA | ROUT | PCE);
        else if (op == 5'd21) ex.push_back(INO | GRA | RIN);
        else if (op == 5'd22) ex.push_back(GRA | ROUT | OPE);
        else if (op == 5'd23) ex.push_back(HIO | GRA | RIN);
        else if (op == 5'd24) ex.push_back(LOO | GRA | RIN);
        else ex.push_back(34'd0);
        n = (ex.size() < limit) ? ex.size() : limit;
        for (int i = 0; i < n; i++) exp_q.push_back(ex[i] | RUN);
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic con, input int limit);
        int n;
        IR = ir;
        CON_FF = con;
        model_instr(ir, con, limit, n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Clear for one cycle; 'cur' is what the current cycle shows before the reset edge.
    task automatic clear_pulse(input vec_t cur);
        exp_q.push_back(cur);
        Clear = 1'b1;
        @(posedge clk); #1;
        Clear = 1'b0;
        exp_q.push_back(RUN);
        @(posedge clk); #1;
    endtask

    // Monitor: every cycle that has an expectation queued is compared against the DUT.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (act === e) n_pass = n_pass + 1;
            else $display("FAIL step_outputs cycle %0d: got %h expected %h", cyc, act, e);
        end
    end

    initial begin
        int n;
        logic [4:0] op;
        Clear = 1'b1; IR = 32'd0; CON_FF = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(RUN);
        @(posedge clk); #1;
        exp_q.push_back(RUN);
        Clear = 1'b0;
        @(posedge clk); #1;

        run_instr(32'h59080002, 1'b0, 99);   // addi r2,r1,2
        run_instr(32'h00800055, 1'b1, 99);   // ld r1,0x55
        run_instr(32'h10800055, 1'b0, 99);   // st 0x55,r1
        run_instr(32'h08800055, 1'b0, 99);   // ldi
        run_instr(32'h9100000A, 1'b1, 99);   // br taken
        run_instr(32'h9100000A, 1'b0, 99);   // br not taken
        run_instr(32'hC8000000, 1'b1, 99);   // nop

        // mul with Clear asserted during T4
        IR = 32'h71880000;
        CON_FF = 1'b0;
        model_instr(IR, 1'b0, 4, n);
        repeat (n) begin @(posedge clk); #1; end
        clear_pulse(GRB | ROUT | alu(5'b01110) | ZLI | ZHI | RUN);

        for (int k = 0; k < 60; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11010) op = 5'b11001;
            run_instr({op, 27'($urandom)}, 1'($urandom), 99);
        end

        // halt parks for 22 cycles, then Clear restarts fetch
        run_instr(32'hD0000000, 1'b1, 99);
        repeat (22) begin
            exp_q.push_back(34'd0);
            CON_FF = 1'($urandom);
            @(posedge clk); #1;
        end
        clear_pulse(34'd0);
        run_instr(32'h81000000, 1'b0, 99);   // neg after restart

        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks = n_checks + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
